branch_resolver: RTL and testbench
==================================

# branch_resolver

Resolves each branch or jump in ID against the prediction made for it in IF. Drives the pipeline flush and PC redirect on a misprediction and produces the one-shot training update for the branch target buffer. Sits beside the IF/ID pipeline register: it carries each fetched PC and its prediction into ID, compares it with the resolved outcome, and talks back to the predictor's update port.

## Interface
- `WORD_SIZE`, 16: PC / instruction-address width.
- `clk` input 1: clock.
- `reset_n` input 1: synchronous, active-low reset.
- `if_valid` input 1: IF holds a real fetched instruction this cycle.
- `if_pc` input WORD_SIZE: PC fetched in IF.
- `if_pred_pc` input WORD_SIZE: predicted next PC issued by the predictor for `if_pc`.
- `if_pred_taken` input 1: predictor's taken bit for `if_pc`.
- `stall` input 1: hazard stall. IF/ID holds and the tracking register holds.
- `id_branch` input 1: ID instruction is a conditional branch.
- `id_jump` input 1: ID instruction is an unconditional jump.
- `id_bcond` input 1: resolved branch condition.
- `id_target` input WORD_SIZE: resolved branch/jump target.
- `flush` output 1: squash the IF and ID instructions this cycle.
- `redirect_valid` output 1: the PC mux must select `redirect_pc`.
- `redirect_pc` output WORD_SIZE: correct next PC.
- `upd_valid` output 1: predictor update strobe, one pulse per resolved branch/jump.
- `upd_pc` output WORD_SIZE: update index PC.
- `upd_branch` output 1: update field for conditional branches.
- `upd_jump` output 1: update field for jumps.
- `upd_bcond` output 1: update field for the resolved condition.
- `upd_target` output WORD_SIZE: update field for the target.
- `stat_branches` output 16: count of resolved branches and jumps (see Configuration).
- `stat_mispredicts` output 16: count of mispredictions (see Configuration).

## Operation
- Tracking register `{t_valid, t_pc, t_pred_pc, t_pred_taken, t_done}` mirrors IF/ID.
  - It loads from the IF inputs on each posedge where `stall`=0 and state=IDLE, with `t_done`=0.
  - It loads `t_valid`=0 whenever state=FLUSH.
- Resolution is combinational in ID.
  - `actual_pc` = `id_target` if (`id_jump` | (`id_branch` & `id_bcond`)), else `t_pc`+1, computed modulo 2^WORD_SIZE.
  - `resolve` = `t_valid` & ~`t_done` & (`id_branch` | `id_jump`) & state==IDLE.
  - `mispredict` = `resolve` & (`actual_pc` != `t_pred_pc`).
  - A non-branch instruction is never checked. The predictor only redirects on tagged hits, so its fall-through is always `pc`+1.
- FSM states: IDLE, FLUSH.
  - IDLE → FLUSH on `mispredict`. The register `r_pc` latches `actual_pc`.
  - FLUSH → IDLE unconditionally after one cycle.
- In FLUSH, both `flush` and `redirect_valid` are 1 and `redirect_pc`=`r_pc`. This holds regardless of `stall`: flush overrides stall.
- Predictor update outputs:
  - Registered. At the posedge after `resolve`, `upd_valid`=1 for exactly one cycle.
  - `upd_pc`=`t_pc` and `upd_target`=`id_target`; `upd_branch`, `upd_jump` and `upd_bcond` are sampled from the ID inputs.
- `t_done` is set with `resolve`. A stalled branch held in ID therefore produces only one update and one mispredict.
- `id_branch` and `id_jump` both high: treated as a jump. `upd_branch` is forced to 0.

## Timing
- Reset (posedge with `reset_n`=0):
  - State=IDLE and `t_valid`=0.
  - `flush`=0, `redirect_valid`=0, `redirect_pc`=0.
  - `upd_valid`=0 and every upd_* field=0.
  - Both stat counters=0.
- Reset mid-FLUSH aborts the redirect: the next cycle is IDLE with outputs at their reset values.
- Mispredict latency:
  - Detected in cycle N.
  - `flush`/`redirect_valid` high in cycle N+1 only.
  - The correct-path fetch happens in N+2.
- Update latency: `upd_valid` rises one cycle after `resolve`. It coincides with FLUSH when the branch mispredicted.
- `flush` and `redirect_valid` are never high for two consecutive cycles. Back-to-back mispredicts are impossible because FLUSH invalidates the tracking entry.

## Configuration
- `BRANCH_STATS_EN` defined:
  - `stat_branches` increments on each `resolve`.
  - `stat_mispredicts` increments on each `mispredict`.
  - Both are 16-bit, saturate at 16'hFFFF and clear only on reset.
- `BRANCH_STATS_EN` undefined: no counter logic; both ports are driven constant 0.

## Test plan
- Predicted-correct taken branch: `if_pc`=0x0010, `if_pred_pc`=0x0020; next cycle `id_branch`=1, `id_bcond`=1, `id_target`=0x0020 → `flush` stays 0; one `upd_valid` pulse with `upd_pc`=0x0010, `upd_bcond`=1.
- Mispredicted not-taken branch: `if_pc`=0x0030, `if_pred_pc`=0x0031; ID `id_branch`=1, `id_bcond`=1, `id_target`=0x0050 → next cycle `flush`=1, `redirect_pc`=0x0050 for exactly 1 cycle; `stat_mispredicts`=1.
- Jump mispredicted as fall-through: `if_pc`=0x00FF, `if_pred_pc`=0x0100; `id_jump`=1, `id_target`=0x0200 → redirect to 0x0200, `upd_jump`=1.
- Stall with branch in ID for 3 cycles, mispredicted → exactly one `upd_valid` pulse and one FLUSH cycle; `stat_branches` increments by 1.
- Wrap-around: `if_pc`=0xFFFF, `if_pred_pc`=0x0000, not-taken branch → no mispredict.
- Reset asserted during FLUSH → next cycle `flush`=0, `redirect_valid`=0, both counters=0; the wrong-path instruction is not resolved afterwards.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch/jump resolution beside IF/ID: flush + redirect on mispredict, one-shot predictor update.
// Optional saturating statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolver #(
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_valid,
  input  logic [WORD_SIZE-1:0] if_pc,
  input  logic [WORD_SIZE-1:0] if_pred_pc,
  input  logic                 if_pred_taken,
  input  logic                 stall,
  input  logic                 id_branch,
  input  logic                 id_jump,
  input  logic                 id_bcond,
  input  logic [WORD_SIZE-1:0] id_target,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 upd_valid,
  output logic [WORD_SIZE-1:0] upd_pc,
  output logic                 upd_branch,
  output logic                 upd_jump,
  output logic                 upd_bcond,
  output logic [WORD_SIZE-1:0] upd_target,
  output logic [15:0]          stat_branches,
  output logic [15:0]          stat_mispredicts
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic                 r_t_valid;
  logic [WORD_SIZE-1:0] r_t_pc;
  logic [WORD_SIZE-1:0] r_t_pred_pc;
  logic                 r_t_pred_taken;
  logic                 r_t_done;
  logic [WORD_SIZE-1:0] r_pc;

  logic                 r_upd_valid;
  logic [WORD_SIZE-1:0] r_upd_pc;
  logic                 r_upd_branch;
  logic                 r_upd_jump;
  logic                 r_upd_bcond;
  logic [WORD_SIZE-1:0] r_upd_target;

  logic                 w_taken;
  logic [WORD_SIZE-1:0] w_actual_pc;
  logic                 w_resolve;
  logic                 w_mispredict;

  assign w_taken      = id_jump | (id_branch & id_bcond);
  assign w_actual_pc  = w_taken ? id_target : r_t_pc + WORD_SIZE'(1);
  assign w_resolve    = r_t_valid & ~r_t_done & (id_branch | id_jump) & (r_state == IDLE);
  assign w_mispredict = w_resolve & (w_actual_pc != r_t_pred_pc);

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next   = r_state;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (r_state)
      IDLE:  if (w_mispredict) w_state_next = FLUSH;
      FLUSH: begin
        w_state_next   = IDLE;
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = r_pc;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FLUSH invalidates the entry even under stall; a stalled resolved entry is marked done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_t_valid      <= 1'b0;
      r_t_pc         <= '0;
      r_t_pred_pc    <= '0;
      r_t_pred_taken <= 1'b0;
      r_t_done       <= 1'b0;
    end else if (r_state == FLUSH) begin
      r_t_valid <= 1'b0;
    end else if (!stall) begin
      r_t_valid      <= if_valid;
      r_t_pc         <= if_pc;
      r_t_pred_pc    <= if_pred_pc;
      r_t_pred_taken <= if_pred_taken;
      r_t_done       <= 1'b0;
    end else if (w_resolve) begin
      r_t_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)          r_pc <= '0;
    else if (w_mispredict) r_pc <= w_actual_pc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_upd_valid  <= 1'b0;
      r_upd_pc     <= '0;
      r_upd_branch <= 1'b0;
      r_upd_jump   <= 1'b0;
      r_upd_bcond  <= 1'b0;
      r_upd_target <= '0;
    end else begin
      r_upd_valid <= w_resolve;
      if (w_resolve) begin
        r_upd_pc     <= r_t_pc;
        r_upd_branch <= id_branch & ~id_jump;
        r_upd_jump   <= id_jump;
        r_upd_bcond  <= id_bcond;
        r_upd_target <= id_target;
      end
    end
  end

  // The predictor only redirects on taken hits, so a not-taken prediction must be fall-through.
  always_ff @(posedge clk) begin
    if (reset_n && r_t_valid && !r_t_pred_taken)
      assert (r_t_pred_pc == r_t_pc + WORD_SIZE'(1));
  end

  assign upd_valid  = r_upd_valid;
  assign upd_pc     = r_upd_pc;
  assign upd_branch = r_upd_branch;
  assign upd_jump   = r_upd_jump;
  assign upd_bcond  = r_upd_bcond;
  assign upd_target = r_upd_target;

`ifdef BRANCH_STATS_EN
  logic [15:0] r_stat_branches;
  logic [15:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_resolve && (r_stat_branches != '1))
        r_stat_branches <= r_stat_branches + 16'd1;
      if (w_mispredict && (r_stat_mispredicts != '1))
        r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized traffic vs. a slot model.
module tb_branch_resolver;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n, if_valid, if_pred_taken, stall, id_branch, id_jump, id_bcond;
  logic [15:0] if_pc, if_pred_pc, id_target;
  logic        flush, redirect_valid, upd_valid, upd_branch, upd_jump, upd_bcond;
  logic [15:0] redirect_pc, upd_pc, upd_target, stat_branches, stat_mispredicts;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_resolver #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n), .if_valid(if_valid), .if_pc(if_pc),
    .if_pred_pc(if_pred_pc), .if_pred_taken(if_pred_taken), .stall(stall),
    .id_branch(id_branch), .id_jump(id_jump), .id_bcond(id_bcond), .id_target(id_target),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_branch(upd_branch), .upd_jump(upd_jump),
    .upd_bcond(upd_bcond), .upd_target(upd_target),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  // Reference: the instruction sitting in ID, whether a redirect is in progress, and the last update.
  typedef struct {
    bit          valid;
    logic [15:0] pc;
    logic [15:0] pred;
    bit          done;
  } slot_t;

  slot_t       m_id;
  bit          m_flushing;
  logic [15:0] m_redir;
  bit          m_uv, m_ubr, m_ujp, m_ubc;
  logic [15:0] m_upc, m_utgt;
  int unsigned m_nbr, m_nmp;

  task automatic step(input bit rst_n, input bit st, input bit ifv, input logic [15:0] ipc,
                      input logic [15:0] ipred, input bit itk, input bit br, input bit jp,
                      input bit bc, input logic [15:0] tgt);
    logic [15:0] act;
    bit res, mis;
    if (jp || (br && bc)) act = tgt;
    else                  act = 16'((int'(m_id.pc) + 1) % 65536);
    res = m_id.valid && !m_id.done && (br || jp) && !m_flushing;
    mis = res && (act != m_id.pred);
    reset_n = rst_n; stall = st; if_valid = ifv; if_pc = ipc; if_pred_pc = ipred;
    if_pred_taken = itk; id_branch = br; id_jump = jp; id_bcond = bc; id_target = tgt;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_id = '{1'b0, 16'h0, 16'h0, 1'b0};
      m_flushing = 0; m_redir = 0; m_uv = 0; m_ubr = 0; m_ujp = 0; m_ubc = 0;
      m_upc = 0; m_utgt = 0; m_nbr = 0; m_nmp = 0;
    end else begin
      m_uv = res;
      if (res) begin
        m_upc = m_id.pc; m_utgt = tgt; m_ubr = br && !jp; m_ujp = jp; m_ubc = bc;
        if (m_nbr < 65535) m_nbr++;
      end
      if (mis && m_nmp < 65535) m_nmp++;
      if (m_flushing) begin
        m_id.valid = 0;
        m_flushing = 0;
      end else begin
        if (mis) begin m_flushing = 1; m_redir = act; end
        if (!st) m_id = '{ifv, ipc, ipred, 1'b0};
        else if (res) m_id.done = 1;
      end
    end
  endtask

  task automatic nop();
    step(1, 0, 0, 16'h0, 16'h1, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic fetch(input logic [15:0] pc, input logic [15:0] pred, input bit tk);
    step(1, 0, 1, pc, pred, tk, 0, 0, 0, 16'h0);
  endtask

  task automatic test_reset();
    step(0, 0, 1, 16'h1234, 16'h1235, 0, 1, 1, 1, 16'hBEEF);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL reset_flush got=%b want=0", flush); end
    checks++; if (redirect_valid !== 1'b0) begin failures++; $display("FAIL reset_rv got=%b want=0", redirect_valid); end
    checks++; if (redirect_pc !== 16'h0) begin failures++; $display("FAIL reset_rpc got=%h want=0000", redirect_pc); end
    checks++; if ({upd_valid, upd_branch, upd_jump, upd_bcond} !== 4'b0) begin failures++; $display("FAIL reset_upd_bits got=%b want=0000", {upd_valid, upd_branch, upd_jump, upd_bcond}); end
    checks++; if ({upd_pc, upd_target} !== 32'h0) begin failures++; $display("FAIL reset_upd_fields got=%h want=0", {upd_pc, upd_target}); end
    checks++; if ({stat_branches, stat_mispredicts} !== 32'h0) begin failures++; $display("FAIL reset_stats got=%h want=0", {stat_branches, stat_mispredicts}); end
    step(1, 0, 0, 16'h0, 16'h1, 0, 1, 0, 1, 16'h0040);
    checks++; if (upd_valid !== 1'b0) begin failures++; $display("FAIL reset_no_resolve got=%b want=0", upd_valid); end
  endtask

  task automatic test_correct_taken();
    step(0, 0, 0, 16'h0, 16'h1, 0, 0, 0, 0, 16'h0);
    fetch(16'h0010, 16'h0020, 1);
    step(1, 0, 0, 16'h0, 16'h1, 0, 1, 0, 1, 16'h0020);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL taken_ok_flush got=%b want=0", flush); end
    checks++; if (upd_valid !== 1'b1) begin failures++; $display("FAIL taken_ok_upd_valid got=%b want=1", upd_valid); end
    checks++; if (upd_pc !== 16'h0010) begin failures++; $display("FAIL taken_ok_upd_pc got=%h want=0010", upd_pc); end
    checks++; if ({upd_branch, upd_jump, upd_bcond} !== 3'b101) begin failures++; $display("FAIL taken_ok_upd_bits got=%b want=101", {upd_branch, upd_jump, upd_bcond}); end
    checks++; if (upd_target !== 16'h0020) begin failures++; $display("FAIL taken_ok_upd_target got=%h want=0020", upd_target); end
    nop();
    checks++; if ({upd_valid, flush} !== 2'b00) begin failures++; $display("FAIL taken_ok_after got=%b want=00", {upd_valid, flush}); end
  endtask

  task automatic test_mispredict_branch();
    step(0, 0, 0, 16'h0, 16'h1, 0, 0, 0, 0, 16'h0);
    fetch(16'h0030, 16'h0031, 0);
    step(1, 0, 1, 16'h0031, 16'h0032, 0, 1, 0, 1, 16'h0050);
    checks++; if ({flush, redirect_valid} !== 2'b11) begin failures++; $display("FAIL mis_flush got=%b want=11", {flush, redirect_valid}); end
    checks++; if (redirect_pc !== 16'h0050) begin failures++; $display("FAIL mis_rpc got=%h want=0050", redirect_pc); end
    checks++; if (upd_valid !== 1'b1) begin failures++; $display("FAIL mis_upd_valid got=%b want=1", upd_valid); end
    step(1, 0, 1, 16'h0032, 16'h0033, 0, 1, 0, 1, 16'h0077);
    checks++; if ({flush, redirect_valid, upd_valid} !== 3'b000) begin failures++; $display("FAIL mis_one_cycle got=%b want=000", {flush, redirect_valid, upd_valid}); end
    checks++; if (stat_mispredicts !== (STATS ? 16'd1 : 16'd0)) begin failures++; $display("FAIL mis_stat got=%0d want=%0d", stat_mispredicts, STATS ? 1 : 0); end
    step(1, 0, 1, 16'h0050, 16'h0051, 0, 1, 0, 1, 16'h0077);
    checks++; if ({flush, upd_valid} !== 2'b00) begin failures++; $display("FAIL mis_wrong_path got=%b want=00", {flush, upd_valid}); end
  endtask

  task automatic test_jump();
    step(0, 0, 0, 16'h0, 16'h1, 0, 0, 0, 0, 16'h0);
    fetch(16'h00FF, 16'h0100, 0);
    step(1, 0, 0, 16'h0, 16'h1, 0, 0, 1, 0, 16'h0200);
    checks++; if (flush !== 1'b1 || redirect_pc !== 16'h0200) begin failures++; $display("FAIL jump_redirect got=%b/%h want=1/0200", flush, redirect_pc); end
    checks++; if ({upd_valid, upd_branch, upd_jump} !== 3'b101 || upd_pc !== 16'h00FF) begin failures++; $display("FAIL jump_upd got=%b/%h want=101/00ff", {upd_valid, upd_branch, upd_jump}, upd_pc); end
    nop();
    fetch(16'h0040, 16'h0041, 0);
    step(1, 0, 0, 16'h0, 16'h1, 0, 1, 1, 0, 16'h0060);
    checks++; if (flush !== 1'b1 || redirect_pc !== 16'h0060) begin failures++; $display("FAIL both_redirect got=%b/%h want=1/0060", flush, redirect_pc); end
    checks++; if ({upd_branch, upd_jump, upd_bcond} !== 3'b010) begin failures++; $display("FAIL both_upd_bits got=%b want=010", {upd_branch, upd_jump, upd_bcond}); end
    nop();
  endtask

  task automatic test_stall();
    int nf, nu;
    bit prev;
    logic [15:0] seen;
    step(0, 0, 0, 16'h0, 16'h1, 0, 0, 0, 0, 16'h0);
    fetch(16'h0070, 16'h0071, 0);
    nf = 0; nu = 0; prev = 0; seen = 16'h0;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 16'h0071, 16'h0072, 0, 1, 0, 1, 16'h0090);
      if (flush) begin nf++; seen = redirect_pc; end
      if (upd_valid) nu++;
      checks++; if (prev && flush) begin failures++; $display("FAIL stall_double_flush got=1 want=0"); end
      prev = flush;
    end
    checks++; if (nf != 1 || nu != 1) begin failures++; $display("FAIL stall_mis_counts got=%0d/%0d want=1/1", nf, nu); end
    checks++; if (seen !== 16'h0090) begin failures++; $display("FAIL stall_rpc got=%h want=0090", seen); end
    checks++; if (stat_branches !== (STATS ? 16'd1 : 16'd0)) begin failures++; $display("FAIL stall_stat got=%0d want=%0d", stat_branches, STATS ? 1 : 0); end
    fetch(16'h0080, 16'h0090, 1);
    nf = 0; nu = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 1, 16'h0090, 16'h0091, 0, 1, 0, 1, 16'h0090);
      if (flush) nf++;
      if (upd_valid) nu++;
    end
    checks++; if (nf != 0 || nu != 1) begin failures++; $display("FAIL stall_ok_counts got=%0d/%0d want=0/1", nf, nu); end
    checks++; if (stat_branches !== (STATS ? 16'd2 : 16'd0)) begin failures++; $display("FAIL stall_ok_stat got=%0d want=%0d", stat_branches, STATS ? 2 : 0); end
  endtask

  task automatic test_wrap();
    step(0, 0, 0, 16'h0, 16'h1, 0, 0, 0, 0, 16'h0);
    fetch(16'hFFFF, 16'h0000, 0);
    step(1, 0, 0, 16'h0, 16'h1, 0, 1, 0, 0, 16'h1234);
    checks++; if (flush !== 1'b0) begin failures++; $display("FAIL wrap_flush got=%b want=0", flush); end
    checks++; if (upd_valid !== 1'b1 || upd_pc !== 16'hFFFF || upd_bcond !== 1'b0) begin failures++; $display("FAIL wrap_upd got=%b/%h/%b want=1/ffff/0", upd_valid, upd_pc, upd_bcond); end
    checks++; if (stat_mispredicts !== 16'd0) begin failures++; $display("FAIL wrap_stat got=%0d want=0", stat_mispredicts); end
  endtask

  task automatic test_reset_in_flush();
    step(0, 0, 0, 16'h0, 16'h1, 0, 0, 0, 0, 16'h0);
    fetch(16'h0030, 16'h0031, 0);
    step(1, 0, 1, 16'h0031, 16'h0032, 0, 1, 0, 1, 16'h0050);
    checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rif_pre_flush got=%b want=1", flush); end
    step(0, 0, 1, 16'h0032, 16'h0033, 0, 1, 0, 1, 16'h0050);
    checks++; if ({flush, redirect_valid, upd_valid} !== 3'b000 || redirect_pc !== 16'h0) begin failures++; $display("FAIL rif_outputs got=%b/%h want=000/0000", {flush, redirect_valid, upd_valid}, redirect_pc); end
    checks++; if ({stat_branches, stat_mispredicts} !== 32'h0) begin failures++; $display("FAIL rif_stats got=%h want=0", {stat_branches, stat_mispredicts}); end
    step(1, 1, 1, 16'h0033, 16'h0034, 0, 1, 0, 1, 16'h0099);
    checks++; if ({flush, upd_valid} !== 2'b00) begin failures++; $display("FAIL rif_no_resolve got=%b want=00", {flush, upd_valid}); end
  endtask

  task automatic test_random();
    bit prev;
    logic [15:0] pc, pred, tgt;
    bit tk;
    step(0, 0, 0, 16'h0, 16'h1, 0, 0, 0, 0, 16'h0);
    prev = 0;
    for (int i = 0; i < 800; i++) begin
      pc  = 16'($urandom_range(0, 15)) + ((($urandom & 7) == 0) ? 16'hFFF0 : 16'h0);
      tgt = 16'($urandom_range(0, 15));
      tk  = 1'($urandom);
      pred = tk ? 16'($urandom_range(0, 15)) : 16'((int'(pc) + 1) % 65536);
      step(($urandom % 60) != 0, ($urandom % 4) == 0, 1'($urandom), pc, pred, tk,
           1'($urandom), ($urandom % 4) == 0, 1'($urandom), tgt);
      checks++; if (flush !== m_flushing || redirect_valid !== m_flushing) begin failures++; $display("FAIL rnd_flush cyc=%0d got=%b/%b want=%b", i, flush, redirect_valid, m_flushing); end
      checks++; if (redirect_pc !== (m_flushing ? m_redir : 16'h0)) begin failures++; $display("FAIL rnd_rpc cyc=%0d got=%h want=%h", i, redirect_pc, m_flushing ? m_redir : 16'h0); end
      checks++; if (upd_valid !== m_uv) begin failures++; $display("FAIL rnd_upd_valid cyc=%0d got=%b want=%b", i, upd_valid, m_uv); end
      if (m_uv) begin
        checks++; if (upd_pc !== m_upc || upd_target !== m_utgt) begin failures++; $display("FAIL rnd_upd_addr cyc=%0d got=%h/%h want=%h/%h", i, upd_pc, upd_target, m_upc, m_utgt); end
        checks++; if ({upd_branch, upd_jump, upd_bcond} !== {m_ubr, m_ujp, m_ubc}) begin failures++; $display("FAIL rnd_upd_bits cyc=%0d got=%b want=%b", i, {upd_branch, upd_jump, upd_bcond}, {m_ubr, m_ujp, m_ubc}); end
      end
      checks++; if (stat_branches !== (STATS ? 16'(m_nbr) : 16'h0) || stat_mispredicts !== (STATS ? 16'(m_nmp) : 16'h0)) begin failures++; $display("FAIL rnd_stats cyc=%0d got=%0d/%0d want=%0d/%0d", i, stat_branches, stat_mispredicts, STATS ? m_nbr : 0, STATS ? m_nmp : 0); end
      checks++; if (prev && flush) begin failures++; $display("FAIL rnd_double_flush cyc=%0d got=1 want=0", i); end
      prev = flush;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; stall = 0; if_valid = 0; if_pc = 0; if_pred_pc = 16'h1; if_pred_taken = 0;
    id_branch = 0; id_jump = 0; id_bcond = 0; id_target = 0;
    @(negedge clk);
    test_reset();
    test_correct_taken();
    test_mispredict_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_reset_in_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
